// File: rtl/fcpu_pkg.sv
// Shared AXI response codes, UART register map and FSM state types for the io responder.
package fcpu_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi_resp_t;

    localparam logic [1:0] UART_REG_DATA   = 2'd0;
    localparam logic [1:0] UART_REG_STATUS = 2'd1;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_BEAT
    } rd_state_t;

    function automatic logic uart_reg_mapped(input logic [1:0] sel);
        return (sel == UART_REG_DATA) || (sel == UART_REG_STATUS);
    endfunction

endpackage

// File: rtl/io_byte_fifo.sv
// Small synchronous FIFO with a combinational head; pointers carry an extra MSB
// so full and empty are distinguished without a separate count.
module io_byte_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
    end

endmodule

// File: rtl/uart_axi_responder.sv
// AXI4 slave bridging CPU io accesses to UART byte streams (DATA at 0x0, STATUS at 0x4).
// Optional receive buffering is enabled with the UART_AXI_RX_FIFO_EN macro.
module uart_axi_responder
    import fcpu_pkg::*;
#(
    parameter int ID_W     = 4,
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [ID_W-1:0] s_awid,
    input  logic [31:0]     s_awaddr,
    input  logic [7:0]      s_awlen,
    input  logic            s_awvalid,
    output logic            s_awready,
    input  logic [31:0]     s_wdata,
    input  logic [3:0]      s_wstrb,
    input  logic            s_wlast,
    input  logic            s_wvalid,
    output logic            s_wready,
    output logic [ID_W-1:0] s_bid,
    output logic [1:0]      s_bresp,
    output logic            s_bvalid,
    input  logic            s_bready,
    input  logic [ID_W-1:0] s_arid,
    input  logic [31:0]     s_araddr,
    input  logic [7:0]      s_arlen,
    input  logic            s_arvalid,
    output logic            s_arready,
    output logic [ID_W-1:0] s_rid,
    output logic [31:0]     s_rdata,
    output logic [1:0]      s_rresp,
    output logic            s_rlast,
    output logic            s_rvalid,
    input  logic            s_rready,
    output logic [7:0]      tx_data,
    output logic            tx_valid,
    input  logic            tx_ready,
    input  logic [7:0]      rx_data,
    input  logic            rx_valid,
    output logic            rx_ready
);

    wr_state_t       r_wr_state;
    logic            r_awready;
    logic [ID_W-1:0] r_awid;
    logic [1:0]      r_wsel;
    logic            r_bvalid;
    axi_resp_t       r_bresp;
    logic [ID_W-1:0] r_bid;

    rd_state_t       r_rd_state;
    logic            r_arready;
    logic [ID_W-1:0] r_rid;
    logic [1:0]      r_rsel;
    logic [7:0]      r_rcnt;
    logic [2:0]      r_status;

    logic            w_tx_full;
    logic            w_tx_empty;
    logic            w_tx_push;
    logic            w_wready;
    logic            w_w_hs;
    logic            w_rd_busy;
    logic            w_rd_data_sel;
    logic            w_r_hs;
    logic            w_rx_pop;
    logic            w_rx_avail;
    logic [7:0]      w_rx_byte;
    logic [2:0]      w_status;
    logic            w_unused;

    assign w_unused = ^{s_awaddr[31:4], s_awaddr[1:0], s_awlen,
                        s_araddr[31:4], s_araddr[1:0], s_wdata[31:8], s_wstrb[3:1]};

    // ---------------- transmit path ----------------
    assign w_wready  = (r_wr_state == W_DATA) && ((r_wsel != UART_REG_DATA) || !w_tx_full);
    assign w_w_hs    = s_wvalid && w_wready;
    assign w_tx_push = w_w_hs && (r_wsel == UART_REG_DATA) && s_wstrb[0];

    io_byte_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_tx_push),
        .i_din   (s_wdata[7:0]),
        .i_pop   (tx_ready),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty),
        .o_head  (tx_data)
    );

    assign tx_valid = !w_tx_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_state <= W_IDLE;
            r_awready  <= 1'b0;
            r_awid     <= '0;
            r_wsel     <= '0;
            r_bvalid   <= 1'b0;
            r_bresp    <= OKAY;
            r_bid      <= '0;
        end else begin
            case (r_wr_state)
                W_IDLE: begin
                    if (r_awready && s_awvalid) begin
                        r_awready  <= 1'b0;
                        r_awid     <= s_awid;
                        r_wsel     <= s_awaddr[3:2];
                        r_wr_state <= W_DATA;
                    end else begin
                        r_awready <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_w_hs && s_wlast) begin
                        r_bvalid   <= 1'b1;
                        r_bid      <= r_awid;
                        r_bresp    <= uart_reg_mapped(r_wsel) ? OKAY : DECERR;
                        r_wr_state <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (s_bready) begin
                        r_bvalid   <= 1'b0;
                        r_awready  <= 1'b1;
                        r_wr_state <= W_IDLE;
                    end
                end
                default: r_wr_state <= W_IDLE;
            endcase
        end
    end

    assign s_awready = r_awready;
    assign s_wready  = w_wready;
    assign s_bvalid  = r_bvalid;
    assign s_bresp   = r_bresp;
    assign s_bid     = r_bid;

    // ---------------- receive path ----------------
    assign w_rd_busy     = (r_rd_state == R_BEAT);
    assign w_rd_data_sel = w_rd_busy && (r_rsel == UART_REG_DATA);
    assign w_r_hs        = s_rvalid && s_rready;
    assign w_rx_pop      = w_r_hs && w_rd_data_sel;

`ifdef UART_AXI_RX_FIFO_EN
    logic w_rx_full;
    logic w_rx_empty;

    io_byte_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (rx_valid),
        .i_din   (rx_data),
        .i_pop   (w_rx_pop),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty),
        .o_head  (w_rx_byte)
    );

    assign rx_ready   = !w_rx_full;
    assign w_rx_avail = !w_rx_empty;
`else
    // Without buffering the receiver holds its byte until the CPU read consumes it.
    logic [32:0] w_unused_rx;

    assign w_unused_rx = {w_rx_pop, RX_DEPTH};
    assign rx_ready    = w_rd_data_sel && s_rready;
    assign w_rx_avail  = rx_valid;
    assign w_rx_byte   = rx_data;
`endif

    assign w_status = {w_tx_empty, w_tx_full, w_rx_avail};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_state <= R_IDLE;
            r_arready  <= 1'b0;
            r_rid      <= '0;
            r_rsel     <= '0;
            r_rcnt     <= '0;
            r_status   <= '0;
        end else begin
            case (r_rd_state)
                R_IDLE: begin
                    if (r_arready && s_arvalid) begin
                        r_arready  <= 1'b0;
                        r_rid      <= s_arid;
                        r_rsel     <= s_araddr[3:2];
                        r_rcnt     <= s_arlen;
                        r_status   <= w_status;
                        r_rd_state <= R_BEAT;
                    end else begin
                        r_arready <= 1'b1;
                    end
                end
                R_BEAT: begin
                    if (w_r_hs) begin
                        if (r_rcnt == 8'd0) begin
                            r_arready  <= 1'b1;
                            r_rd_state <= R_IDLE;
                        end else begin
                            r_rcnt   <= r_rcnt - 8'd1;
                            r_status <= w_status;
                        end
                    end
                end
                default: r_rd_state <= R_IDLE;
            endcase
        end
    end

    assign s_arready = r_arready;
    assign s_rid     = r_rid;
    assign s_rvalid  = w_rd_busy && ((r_rsel != UART_REG_DATA) || w_rx_avail);
    assign s_rlast   = w_rd_busy && (r_rcnt == 8'd0);
    assign s_rresp   = (w_rd_busy && !uart_reg_mapped(r_rsel)) ? DECERR : OKAY;

    always_comb begin
        s_rdata = 32'd0;
        if (w_rd_data_sel && w_rx_avail)
            s_rdata = {24'd0, w_rx_byte};
        else if (w_rd_busy && (r_rsel == UART_REG_STATUS))
            s_rdata = {29'd0, r_status};
    end

endmodule
